// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR pattern generator: FSM states,
// config register addresses and the default tap mask.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_SEED  = 2'd0;
    localparam logic [1:0] ADDR_STOP  = 2'd1;
    localparam logic [1:0] ADDR_TAPS  = 2'd2;
    localparam logic [1:0] ADDR_LIMIT = 2'd3;

    // Bits 12 and 3; truncated to WIDTH at the point of use.
    localparam logic [31:0] DEFAULT_TAPS = 32'h0000_1008;

endpackage

// File: rtl/lfsr_step.sv
// Combinational word advance: STEP XNOR-feedback left shifts of an LFSR state.
module lfsr_step #(
    parameter int WIDTH = 24,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = state;
        for (int i = 0; i < STEP; i++) begin
            next = {next[WIDTH-2:0], ~^(next & taps)};
        end
    end

endmodule

// File: rtl/lfsr_pattern_gen.sv
// Programmable LFSR word source with valid/ready output and a small config
// register file. Define LFSR_PATTERN_LIMIT_EN to add the word-limit register.
//
// state | meaning
// IDLE  | no run; config writable
// RUN   | emitting words, starting from seed
// DONE  | last word accepted; config writable, start re-runs
module lfsr_pattern_gen
    import lfsr_pkg::*;
#(
    parameter int              WIDTH = 24,
    parameter int              STEP  = 1,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cfg_wr_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [WIDTH-1:0] cfg_data_i,
    output logic [WIDTH-1:0] cfg_rd_data_o,
    output logic             cfg_ack_o,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             lockup_o
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] seed, stop, taps, word, word_adv;
    logic             cfg_ack, lockup;
    logic             accept, locked, limit_hit, last, cfg_ok, load;

    lfsr_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .state (word),
        .taps  (taps),
        .next  (word_adv)
    );

`ifdef LFSR_PATTERN_LIMIT_EN
    logic [WIDTH-1:0] limit, count;
    // count holds words already accepted, so the current word is count+1.
    assign limit_hit = (limit != '0) && (count == limit - WIDTH'(1));
    assign cfg_ok    = cfg_wr_i && (state != RUN);
`else
    assign limit_hit = 1'b0;
    assign cfg_ok    = cfg_wr_i && (state != RUN) && (cfg_addr_i != ADDR_LIMIT);
`endif

    assign locked = (word_adv == word);
    assign last   = (word == stop) || locked || limit_hit;
    assign accept = (state == RUN) && out_ready_i;
    assign load   = (state != RUN) && (state_nxt == RUN);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i && !abort_i) state_nxt = RUN;
            RUN: begin
                if (abort_i)            state_nxt = IDLE;
                else if (accept && last) state_nxt = DONE;
            end
            DONE: begin
                if (abort_i)      state_nxt = IDLE;
                else if (start_i) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seed    <= '0;
            stop    <= '0;
            taps    <= TAPS;
            word    <= '0;
            cfg_ack <= 1'b0;
            lockup  <= 1'b0;
`ifdef LFSR_PATTERN_LIMIT_EN
            limit   <= '0;
            count   <= '0;
`endif
        end else begin
            cfg_ack <= cfg_ok;
            if (cfg_ok) begin
                case (cfg_addr_i)
                    ADDR_SEED: seed  <= cfg_data_i;
                    ADDR_STOP: stop  <= cfg_data_i;
                    ADDR_TAPS: taps  <= cfg_data_i;
`ifdef LFSR_PATTERN_LIMIT_EN
                    default:   limit <= cfg_data_i;
`else
                    default: ;
`endif
                endcase
            end
            if (load) begin
                word   <= seed;
                lockup <= 1'b0;
`ifdef LFSR_PATTERN_LIMIT_EN
                count  <= '0;
`endif
            end else if (accept && !abort_i) begin
                if (last) begin
                    lockup <= locked;
                end else begin
                    word  <= word_adv;
`ifdef LFSR_PATTERN_LIMIT_EN
                    count <= count + WIDTH'(1);
`endif
                end
            end
        end
    end

    always_comb begin
        case (cfg_addr_i)
            ADDR_SEED: cfg_rd_data_o = seed;
            ADDR_STOP: cfg_rd_data_o = stop;
            ADDR_TAPS: cfg_rd_data_o = taps;
`ifdef LFSR_PATTERN_LIMIT_EN
            default:   cfg_rd_data_o = limit;
`else
            default:   cfg_rd_data_o = '0;
`endif
        endcase
    end

    assign cfg_ack_o   = cfg_ack;
    assign out_valid_o = (state == RUN);
    assign out_data_o  = word;
    assign out_last_o  = (state == RUN) && last;
    assign busy_o      = (state == RUN);
    assign done_o      = (state == DONE);
    assign lockup_o    = lockup;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Scoreboard bench for lfsr_pattern_gen: a STEP=1 and a STEP=4 instance share
// all inputs; each scenario checks the instance it targets.
module tb_lfsr_pattern_gen;
    import lfsr_pkg::*;

    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, cfg_wr, start, abort, out_ready;
    logic [1:0]   cfg_addr;
    logic [W-1:0] cfg_data;

    logic [W-1:0] rd1, data1, rd4, data4;
    logic         ack1, valid1, last1, busy1, done1, lock1;
    logic         ack4, valid4, last4, busy4, done4, lock4;

    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lfsr_pattern_gen #(.WIDTH(W), .STEP(1)) u_dut (
        .clk_i(clk), .reset_i(reset), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .cfg_rd_data_o(rd1), .cfg_ack_o(ack1),
        .start_i(start), .abort_i(abort), .out_valid_o(valid1), .out_ready_i(out_ready),
        .out_data_o(data1), .out_last_o(last1), .busy_o(busy1), .done_o(done1),
        .lockup_o(lock1)
    );

    lfsr_pattern_gen #(.WIDTH(W), .STEP(4)) u_dut4 (
        .clk_i(clk), .reset_i(reset), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .cfg_rd_data_o(rd4), .cfg_ack_o(ack4),
        .start_i(start), .abort_i(abort), .out_valid_o(valid4), .out_ready_i(out_ready),
        .out_data_o(data4), .out_last_o(last4), .busy_o(busy4), .done_o(done4),
        .lockup_o(lock4)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks enter and leave at a falling edge: sample first, then drive.
    task automatic do_reset();
        reset = 1'b1; cfg_wr = 1'b0; cfg_addr = ADDR_SEED; cfg_data = '0;
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [W-1:0] d,
                             input logic exp_ack, input logic [W-1:0] exp_rd);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
        vectors++;
        if (ack1 !== exp_ack || ack4 !== exp_ack) begin
            errors++;
            $display("FAIL cfg_ack addr %0d: got %b/%b, want %b", a, ack1, ack4, exp_ack);
        end
        vectors++;
        if (rd1 !== exp_rd) begin
            errors++;
            $display("FAIL cfg_rd addr %0d: got %h, want %h", a, rd1, exp_rd);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d, input logic l);
        exp_t e;
        e.data = d; e.last = l;
        sb.push_back(e);
    endtask

    task automatic drain(input bit use4, input int budget, input int stall_from,
                         input int stall_len, output int cycles);
        logic         v, l;
        logic [W-1:0] d;
        exp_t         e;
        cycles = 0;
        while (sb.size() > 0 && cycles < budget) begin
            out_ready = !(cycles >= stall_from && cycles < stall_from + stall_len);
            v = use4 ? valid4 : valid1;
            d = use4 ? data4  : data1;
            l = use4 ? last4  : last1;
            e = sb[0];
            vectors++;
            if (v !== 1'b1 || d !== e.data || l !== e.last) begin
                errors++;
                $display("FAIL word step%0d cyc %0d: got v=%b %h last %b, want v=1 %h last %b",
                         use4 ? 4 : 1, cycles, v, d, l, e.data, e.last);
            end
            if (out_ready) void'(sb.pop_front());
            cycles++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (sb.size() > 0) begin
            vectors++; errors++;
            $display("FAIL drain timeout: %0d words still expected", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_done(input bit use4, input string name);
        logic [2:0] got;
        got = use4 ? {valid4, busy4, done4} : {valid1, busy1, done1};
        vectors++;
        if (got !== 3'b001) begin
            errors++;
            $display("FAIL %s done: got valid/busy/done %b, want 001", name, got);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({valid1, last1, busy1, done1, lock1, ack1, data1} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got v%b l%b b%b d%b lk%b a%b %h, want all 0",
                     valid1, last1, busy1, done1, lock1, ack1, data1);
        end
        cfg_addr = ADDR_TAPS;
        #1;
        vectors++;
        if (rd1 !== 24'h001008) begin
            errors++;
            $display("FAIL reset taps: got %h, want 001008", rd1);
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        cfg_write(ADDR_STOP, 24'h00000F, 1'b1, 24'h00000F);
        push(24'h000000, 0); push(24'h000001, 0); push(24'h000003, 0);
        push(24'h000007, 0); push(24'h00000F, 1);
        start_run();
        drain(0, 20, -1, 0, cyc);
        vectors++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL basic throughput: got %0d cycles, want 5", cyc);
        end
        check_done(0, "basic");
    endtask

    task automatic test_step4();
        int cyc;
        do_reset();
        cfg_write(ADDR_STOP, 24'h00000F, 1'b1, 24'h00000F);
        push(24'h000000, 0); push(24'h00000F, 1);
        start_run();
        drain(1, 10, -1, 0, cyc);
        check_done(1, "step4");
        vectors++;
        if (lock4 !== 1'b0 || rd4 !== 24'h00000F) begin
            errors++;
            $display("FAIL step4 status: got lockup %b stop %h, want 0 00000f", lock4, rd4);
        end
    endtask

    task automatic test_lockup();
        int cyc;
        do_reset();
        cfg_write(ADDR_TAPS, 24'h000000, 1'b1, 24'h000000);
        cfg_write(ADDR_SEED, 24'hFFFFFF, 1'b1, 24'hFFFFFF);
        push(24'hFFFFFF, 1);
        start_run();
        drain(0, 10, -1, 0, cyc);
        check_done(0, "lockup");
        vectors++;
        if (lock1 !== 1'b1) begin
            errors++;
            $display("FAIL lockup flag: got %b, want 1", lock1);
        end
        // seed == stop from DONE: single word, lockup cleared by the new start
        cfg_write(ADDR_TAPS, 24'h001008, 1'b1, 24'h001008);
        cfg_write(ADDR_SEED, 24'h000005, 1'b1, 24'h000005);
        cfg_write(ADDR_STOP, 24'h000005, 1'b1, 24'h000005);
        push(24'h000005, 1);
        start_run();
        vectors++;
        if (lock1 !== 1'b0) begin
            errors++;
            $display("FAIL lockup clear: got %b, want 0", lock1);
        end
        drain(0, 10, -1, 0, cyc);
        check_done(0, "single");
    endtask

    task automatic test_back_to_back_stall();
        int cyc;
        do_reset();
        cfg_write(ADDR_STOP, 24'h00000F, 1'b1, 24'h00000F);
        push(24'h000000, 0); push(24'h000001, 0); push(24'h000003, 0);
        push(24'h000007, 0); push(24'h00000F, 1);
        start_run();
        drain(0, 30, 2, 5, cyc);
        vectors++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL stall cycles: got %0d, want 10", cyc);
        end
        check_done(0, "stall");
    endtask

    task automatic test_abort();
        logic [W-1:0] want[3];
        want[0] = 24'h000000; want[1] = 24'h000001; want[2] = 24'h000003;
        do_reset();
        cfg_write(ADDR_STOP, 24'h00000F, 1'b1, 24'h00000F);
        start_run();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (valid1 !== 1'b1 || data1 !== want[i]) begin
                errors++;
                $display("FAIL abort pre word %0d: got v=%b %h, want v=1 %h", i, valid1, data1, want[i]);
            end
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b0; abort = 1'b1;
        cfg_wr = 1'b1; cfg_addr = ADDR_STOP; cfg_data = 24'h000055;
        @(negedge clk);
        abort = 1'b0; cfg_wr = 1'b0;
        vectors++;
        if ({valid1, last1, busy1, done1, ack1, lock1} !== 6'b0) begin
            errors++;
            $display("FAIL abort state: got v%b l%b b%b d%b a%b lk%b, want all 0",
                     valid1, last1, busy1, done1, ack1, lock1);
        end
        vectors++;
        if (rd1 !== 24'h00000F) begin
            errors++;
            $display("FAIL abort stop readback: got %h, want 00000f", rd1);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_limit();
        int cyc;
        do_reset();
`ifdef LFSR_PATTERN_LIMIT_EN
        cfg_write(ADDR_LIMIT, 24'h000003, 1'b1, 24'h000003);
        cfg_write(ADDR_STOP, 24'h123456, 1'b1, 24'h123456);
        push(24'h000000, 0); push(24'h000001, 0); push(24'h000003, 1);
        start_run();
        drain(0, 10, -1, 0, cyc);
        check_done(0, "limit");
`else
        cfg_write(ADDR_LIMIT, 24'h000003, 1'b0, 24'h000000);
        cyc = 0;
`endif
    endtask

    task automatic test_reset_midrun();
        do_reset();
        cfg_write(ADDR_SEED, 24'h000007, 1'b1, 24'h000007);
        start_run();
        vectors++;
        if (valid1 !== 1'b1 || data1 !== 24'h000007) begin
            errors++;
            $display("FAIL midrun start: got v=%b %h, want v=1 000007", valid1, data1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cfg_addr = ADDR_SEED;
        #1;
        vectors++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0 || rd1 !== '0) begin
            errors++;
            $display("FAIL midrun reset: got v=%b b=%b seed %h, want 0 0 000000", valid1, busy1, rd1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step4();
        test_lockup();
        test_back_to_back_stall();
        test_abort();
        test_limit();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_pattern_gen.md
# lfsr_pattern_gen

Parametrised pseudo-random pattern source for the pixel datapath test and dither paths. It holds run-time programmable seed, stop and tap-mask registers, and emits LFSR words over a valid/ready stream. Each run starts from the seed and ends on the stop word, on a lock-up, or on an optional word limit. It supersedes the fixed 24-bit, fixed-tap generator with configurable width, taps and steps-per-word, plus output backpressure.

## Interface
- WIDTH, 24, LFSR state and word width (4..32)
- STEP, 1, shifts applied per emitted word (1..WIDTH)
- TAPS, 24'h001008, reset value of the tap mask (bits 12 and 3)
- clk_i  in  1  clock; one clock domain
- reset_i  in  1  synchronous, active-high reset
- cfg_wr_i  in  1  config write strobe
- cfg_addr_i  in  2  0 = seed, 1 = stop, 2 = taps, 3 = limit
- cfg_data_i  in  WIDTH  write data
- cfg_rd_data_o  out  WIDTH  combinational readback of the register at cfg_addr_i
- cfg_ack_o  out  1  registered one-cycle pulse after an accepted write
- start_i  in  1  begin a run
- abort_i  in  1  terminate a run
- out_valid_o  out  1  word available
- out_ready_i  in  1  consumer accepts the word
- out_data_o  out  WIDTH  current LFSR state
- out_last_o  out  1  final word of the run
- busy_o  out  1  state is RUN
- done_o  out  1  state is DONE
- lockup_o  out  1  last run ended on a lock-up

## Operation
- Reset values: seed = 0, stop = 0, taps = TAPS, limit = 0. All outputs are 0 except cfg_rd_data_o, which is combinational. State is IDLE.
- Feedback bit: fb = XNOR-reduce(state & taps). One shift is next = {state[WIDTH-2:0], fb}. A word advance applies STEP shifts combinationally.
- States:
  - IDLE: waits for start.
  - RUN: loads state = seed on entry; out_valid_o = 1.
  - DONE: holds until start or abort.
- IDLE or DONE, start_i → RUN. Clears lockup_o and the word counter.
- RUN, on accept (valid & ready):
  - If the emitted word was last → DONE.
  - Otherwise state advances and the counter increments.
- out_last_o is asserted with the current word if any of these hold:
  - word == stop
  - advance(word) == word; this also sets lockup_o
  - limit is reached (see Configuration)
- seed == stop gives a single-word run.
- abort_i in RUN or DONE → IDLE next cycle. Valid drops with no last; lockup_o is unchanged.
- start_i with abort_i in the same cycle: abort wins. start_i in RUN is ignored.
- Config writes are accepted only in IDLE or DONE. In RUN they are ignored and produce no cfg_ack_o.
- reset_i mid-run returns every register, including config, to its reset value.

## Timing
- start_i at cycle N → out_valid_o = 1 and out_data_o = seed at N+1.
- Accept at cycle N → next word at N+1. Throughput is one word per cycle with ready held high.
- Accept of the last word at cycle N → out_valid_o = 0 and done_o = 1 at N+1.
- With out_ready_i low, out_data_o and out_last_o hold stable.
- cfg_wr_i at cycle N → register updated and cfg_ack_o = 1 at N+1.

## Configuration
- LFSR_PATTERN_LIMIT_EN defined:
  - Adds a WIDTH-bit limit register at address 3 and a word counter.
  - Word number k (1-based) is last when k == limit, with limit != 0.
  - limit = 0 means unlimited.
- Not defined:
  - Address 3 writes are ignored and produce no ack; reads return 0.
  - No counter is built.

## Structure
- Package lfsr_pkg holds the state enum (IDLE, RUN, DONE), the config address constants (ADDR_SEED, ADDR_STOP, ADDR_TAPS, ADDR_LIMIT) and the default tap mask constant.
- Sub-module lfsr_step: combinational WIDTH/STEP advance (state, taps → next). It is instantiated once and reused for the last/lock-up compare.

## Test plan
- Defaults; seed 0, stop 0x00000F, start, ready high → words 0x000000, 0x000001, 0x000003, 0x000007, 0x00000F; last on 0x00000F; done_o at the following cycle.
- STEP = 4, seed 0, stop 0x00000F → words 0x000000 then 0x00000F with last.
- Taps 0, seed 0xFFFFFF, stop 0 → single word 0xFFFFFF with last; lockup_o = 1.
- out_ready_i low for 5 cycles mid-run → out_data_o stable; no word is skipped or duplicated after release.
- Abort during RUN at word 2, plus a write to stop during RUN → IDLE next cycle; no last; stop readback unchanged; no cfg_ack_o.
- LFSR_PATTERN_LIMIT_EN defined, limit 3, stop 0x123456 → words 0x000000, 0x000001, 0x000003; last on the third word.
